// File: rtl/fp16mul_if.sv
// Operand/result bus of the fp16 multiplier.
// No ready: the device accepts i_a/i_b every cycle i_valid is 1; o_valid marks a new o_res.
interface fp16mul_if;
   logic        i_valid;
   logic [15:0] i_a;
   logic [15:0] i_b;
   logic        o_valid;
   logic [15:0] o_res;

   modport master (output i_valid, output i_a, output i_b, input o_valid, input o_res);
   modport slave  (input i_valid, input i_a, input i_b, output o_valid, output o_res);
endinterface

// File: rtl/fp16mul.sv
// IEEE-754 binary16 multiplier, denormals flushed to zero, NaN treated as inf.
// FP16MUL_PIPE_EN selects a 3-stage pipeline (latency 3); otherwise latency 1.
module fp16mul (
   input logic      clk,
   input logic      rst_n,
   fp16mul_if.slave io_bus
);

   typedef struct packed {
      logic              sign;
      logic              is_inf;
      logic              is_zero;
      logic [21:0]       prod;
      logic signed [6:0] exp;
   } mul_s1_t;

   function automatic mul_s1_t unpack_mul(input logic [15:0] a, input logic [15:0] b);
      mul_s1_t    r;
      logic [4:0] ea;
      logic [4:0] eb;
      ea        = a[14:10];
      eb        = b[14:10];
      r.sign    = a[15] ^ b[15];
      r.is_inf  = (ea == 5'h1F) || (eb == 5'h1F);
      r.is_zero = (ea == 5'h00) || (eb == 5'h00);
      r.prod    = {11'b0, 1'b1, a[9:0]} * {11'b0, 1'b1, b[9:0]};
      r.exp     = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 7'sd15;
      return r;
   endfunction

   function automatic logic [15:0] round_pack(input mul_s1_t s);
      logic [10:0]       sig;
      logic              guard;
      logic              sticky;
      logic [11:0]       rnd;
      logic signed [6:0] e;
      logic [15:0]       res;
      e = s.exp;
      if (s.prod[21]) begin
         sig    = s.prod[21:11];
         guard  = s.prod[10];
         sticky = |s.prod[9:0];
         e      = e + 7'sd1;
      end else begin
         sig    = s.prod[20:10];
         guard  = s.prod[9];
         sticky = |s.prod[8:0];
      end
      // Round to nearest even; a carry-out renormalises to 1.0 of the next binade.
      rnd = {1'b0, sig} + {11'b0, guard & (sticky | sig[0])};
      if (rnd[11]) begin
         sig = rnd[11:1];
         e   = e + 7'sd1;
      end else begin
         sig = rnd[10:0];
      end
      if (s.is_inf)             res = {s.sign, 5'h1F, 10'h000};
      else if (s.is_zero)       res = {s.sign, 15'h0000};
      else if (e <= 7'sd0)      res = {s.sign, 15'h0000};
      else if (e >= 7'sd31)     res = {s.sign, 5'h1F, 10'h000};
      else                      res = {s.sign, e[4:0], sig[9:0]};
      return res;
   endfunction

   mul_s1_t     w_s1;
   logic [15:0] w_res;
   logic        r_o_valid;
   logic [15:0] r_o_res;

   assign w_s1           = unpack_mul(io_bus.i_a, io_bus.i_b);
   assign io_bus.o_valid = r_o_valid;
   assign io_bus.o_res   = r_o_res;

`ifdef FP16MUL_PIPE_EN
   mul_s1_t     r_s1;
   logic        r_v1;
   logic [15:0] r_s2;
   logic        r_v2;

   assign w_res = round_pack(r_s1);

   // Valid bits always advance; data registers load only behind a valid bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1      <= 1'b0;
         r_s1      <= '0;
         r_v2      <= 1'b0;
         r_s2      <= 16'h0000;
         r_o_valid <= 1'b0;
         r_o_res   <= 16'h0000;
      end else begin
         r_v1      <= io_bus.i_valid;
         r_v2      <= r_v1;
         r_o_valid <= r_v2;
         if (io_bus.i_valid) r_s1    <= w_s1;
         if (r_v1)           r_s2    <= w_res;
         if (r_v2)           r_o_res <= r_s2;
      end
   end
`else
   assign w_res = round_pack(w_s1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_o_valid <= 1'b0;
         r_o_res   <= 16'h0000;
      end else begin
         r_o_valid <= io_bus.i_valid;
         if (io_bus.i_valid) r_o_res <= w_res;
      end
   end
`endif

endmodule

// File: tb/tb_fp16mul.sv
// Directed and randomised checks for fp16mul; latency follows FP16MUL_PIPE_EN.
module tb_fp16mul;

`ifdef FP16MUL_PIPE_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_tests;
   int   n_fail;

   logic [15:0] exp_q[$];
   int          due_q[$];
   logic [15:0] last_exp;

   fp16mul_if bus ();

   fp16mul dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Value-level reference: exact double product, then round-to-nearest-even to 11 bits.
   function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
      logic        s;
      int          ea;
      int          eb;
      int          e;
      int          fl;
      real         x;
      real         q;
      real         fr;
      logic [15:0] r;
      s  = a[15] ^ b[15];
      ea = int'(a[14:10]);
      eb = int'(b[14:10]);
      if (ea == 31 || eb == 31) return {s, 15'h7C00};
      if (ea == 0 || eb == 0) return {s, 15'h0000};
      x = real'(1024 + int'(a[9:0])) * real'(1024 + int'(b[9:0]));
      e = ea + eb - 35;
      while (x >= 2.0) begin x = x / 2.0; e++; end
      while (x < 1.0) begin x = x * 2.0; e--; end
      q  = x * 1024.0;
      fl = $rtoi(q);
      fr = q - real'(fl);
      if (fr > 0.5 || (fr == 0.5 && fl[0])) fl++;
      if (fl == 2048) begin fl = 1024; e++; end
      if (e <= 0) r = {s, 15'h0000};
      else if (e >= 31) r = {s, 15'h7C00};
      else r = {s, e[4:0], fl[9:0]};
      return r;
   endfunction

   // ---------------- scoreboard / monitor ----------------
   task automatic monitor();
      logic [15:0] e;
      int          d;
      if (bus.o_valid) begin
         if (exp_q.size() == 0) begin
            check_eq("stale_valid", {31'b0, bus.o_valid}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            d = due_q.pop_front();
            check_eq("result", {16'b0, bus.o_res}, {16'b0, e});
            check_eq("latency", cyc, d);
            last_exp = e;
         end
      end else begin
         check_eq("hold", {16'b0, bus.o_res}, {16'b0, last_exp});
      end
   endtask

   // ---------------- driver ----------------
   task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp);
      @(negedge clk);
      monitor();
      bus.i_valid = v;
      bus.i_a     = a;
      bus.i_b     = b;
      if (v) begin
         exp_q.push_back(exp);
         due_q.push_back(cyc + LAT);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 16'h0000, 16'h0000);
   endtask

   function automatic logic [15:0] rand_normal();
      logic       s;
      logic [4:0] e;
      logic [9:0] m;
      s = 1'($urandom_range(0, 1));
      e = 5'($urandom_range(8, 22));
      m = 10'($urandom_range(0, 1023));
      return {s, e, m};
   endfunction

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] r;
   } vec_t;

   vec_t vecs[11] = '{
      '{16'h3C00, 16'h3C00, 16'h3C00},
      '{16'h4000, 16'hC200, 16'hC600},
      '{16'h3C01, 16'h3C01, 16'h3C02},
      '{16'h7BFF, 16'h4000, 16'h7C00},
      '{16'h0400, 16'h0400, 16'h0000},
      '{16'h0001, 16'h3C00, 16'h0000},
      '{16'h8000, 16'h3C00, 16'h8000},
      '{16'h7E00, 16'h3C00, 16'h7C00},
      '{16'h7C00, 16'h0000, 16'h7C00},
      '{16'hFC00, 16'h4000, 16'hFC00},
      '{16'h3C00, 16'h4000, 16'h4000}
   };

   // ---------------- main sequence ----------------
   initial begin
      logic [15:0] a;
      logic [15:0] b;
      logic        v;
      n_tests     = 0;
      n_fail      = 0;
      last_exp    = 16'h0000;
      bus.i_valid = 1'b0;
      bus.i_a     = 16'h0000;
      bus.i_b     = 16'h0000;
      rst_n       = 1'b1;
      #1 rst_n    = 1'b0;
      #1;
      check_eq("rst_valid", {31'b0, bus.o_valid}, 32'd0);
      check_eq("rst_res", {16'b0, bus.o_res}, 32'd0);
      idle(2);
      rst_n = 1'b1;
      idle(2);

      // Directed vectors back-to-back, then isolated with bubbles.
      foreach (vecs[i]) step(1'b1, vecs[i].a, vecs[i].b, vecs[i].r);
      idle(4);
      foreach (vecs[i]) begin
         step(1'b1, vecs[i].a, vecs[i].b, vecs[i].r);
         idle(LAT + 1);
      end

      // Random stream of normal operands with pseudo-random bubbles.
      for (int i = 0; i < 256; i++) begin
         a = rand_normal();
         b = rand_normal();
         v = ($urandom_range(0, 3) != 0);
         step(v, a, b, ref_mul(a, b));
      end
      idle(LAT + 2);

      // Reset with operations in flight.
      step(1'b1, 16'h3C00, 16'h4000, 16'h4000);
      step(1'b1, 16'h4000, 16'h4000, 16'h4400);
      step(1'b1, 16'h4200, 16'h4000, 16'h4600);
      @(posedge clk);
      #2;
      rst_n       = 1'b0;
      bus.i_valid = 1'b0;
      #1;
      check_eq("midrst_valid", {31'b0, bus.o_valid}, 32'd0);
      check_eq("midrst_res", {16'b0, bus.o_res}, 32'd0);
      exp_q.delete();
      due_q.delete();
      last_exp = 16'h0000;
      idle(2);
      rst_n = 1'b1;
      idle(6);

      // One more transaction after recovery.
      step(1'b1, 16'h4400, 16'hC400, 16'hCC00);
      for (int i = 0; i < LAT + 4 && exp_q.size() != 0; i++) idle(1);
      check_eq("drain", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
